pe_inj_sched: RTL and testbench
===============================

Name: pe_inj_sched

Overview:
Injection scheduler between a PE's two virtual-channel source queues and the router local input port. It shares the single local link between VC0 and VC1. Each VC is locked from head flit to tail flit. Per-VC downstream credits are tracked. The block issues a one-hot grant plus a registered mux select that drives the PE output flit mux.

Parameters:
DEPTH, 4, downstream input-buffer depth per VC; initial and maximum credit count
CW, 3, credit counter width; must satisfy 2^CW > DEPTH

Ports:
clk  input  1  system clock
rst_  input  1  reset, asynchronous, active-low
req  input  2  req[v]=1: VC v queue has a flit at its head
ftype0  input  2  flit type of VC0 head flit (package encoding)
ftype1  input  2  flit type of VC1 head flit
credit_in  input  2  credit_in[v]=1: one slot freed downstream for VC v (single-cycle pulse)
grt  output  2  one-hot grant, combinational; the flit is consumed on this cycle
sel  output  2  registered copy of the last nonzero grt, drives the flit mux
valid  output  1  |grt
lock  output  1  1 while a multi-flit packet owns the link
cred  output  2*CW  {cred1, cred0} current credit counts
err  output  1  sticky protocol error

Behaviour:
- Reset (rst_=0, asynchronous): state=IDLE, rr=0, owner=0, sel=2'b00, cred0=cred1=DEPTH, err=0. The combinational grt is 0 during reset.
- Eligibility: elig[v] = req[v] & (cred[v]!=0).
- FSM states:
  - IDLE, no owner:
    - Grant the eligible VC, giving priority to VC rr. If both VCs are eligible, grant rr. If only one is eligible, grant it.
    - Granted ftype=HEAD: next state LOCK, owner<=v.
    - Granted ftype=HEADTAIL: stay IDLE, rr<=~v.
    - Granted BODY or TAIL while in IDLE: still granted as a single flit, err<=1, stay IDLE, rr<=~v.
  - LOCK, owner o:
    - grt[o] = elig[o]. The other VC is never granted, even if eligible.
    - Owner out of credits or req low: no grant, stay LOCK (no timeout).
    - Granted TAIL: next state IDLE, rr<=~o.
    - Granted BODY: stay LOCK.
    - Granted HEAD or HEADTAIL: err<=1, treated as TAIL (go IDLE).
- Grant latency: 0 cycles, combinational from req, cred and state. All state updates occur at the next posedge clk.
- sel: sel<=grt when grt!=0; otherwise sel holds its value. sel is never 2'b11.
- Credit counters, per VC, evaluated each cycle:
  - Grant only: decrement.
  - credit_in only: increment.
  - Both in the same cycle: unchanged.
  - Increment while cred==DEPTH with no grant: counter stays DEPTH, err<=1.
  - A decrement can never occur at 0, since 0 credits makes the VC ineligible.
- err is cleared only by reset.
- Reset asserted mid-packet: immediate return to IDLE with full credits. The upstream queue is flushed by the same reset.
- lock = (state==LOCK). valid = |grt.

Decomposition:
- Shared package noc_pkg:
  - Flit type constants: HEAD=2'b00, BODY=2'b01, TAIL=2'b10, HEADTAIL=2'b11.
  - VC count constant NVC=2.
  - FSM state encoding: IDLE=1'b0, LOCK=1'b1.
- One sub-module: inj_credit_cnt, instantiated per VC. It holds the up/down counter with saturation and overflow flag, with parameters DEPTH and CW. The FSM, round-robin pointer and grant logic stay in the top module.

Test Plan:
- Reset then idle: rst_ low to high, req=00 -> grt=00, sel=00, cred0=cred1=4, lock=0, err=0.
- Single-flit contention: req=11, both HEADTAIL, held for 4 cycles, no credit_in -> grt sequence 01,10,01,10; final cred0=cred1=2; lock stays 0.
- Packet lock: VC0 sends HEAD,BODY,TAIL with req=11 and VC1 HEADTAIL -> grt=01 for 3 cycles with lock=1 on cycles 2-3, then grt=10. sel=01 until the cycle after VC1's grant, then 10.
- Credit stall: DEPTH=4, VC0 packet of 6 flits, no credit_in -> 4 grants then grt=00 with lock=1 and VC1 blocked. A credit_in[0] pulse -> the next cycle grants VC0. A simultaneous grant and credit_in leaves cred unchanged.
- Protocol error and overflow: a BODY flit in IDLE -> granted, err=1. Separately, credit_in[1] at cred1=4 -> cred1 stays 4, err=1.
- Async reset mid-packet: rst_ driven low between clock edges while lock=1 -> lock, sel and grt go to 0 immediately; credits return to 4.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, VC count, injector FSM states.
package noc_pkg;

    localparam int NVC = 2;

    localparam logic [1:0] HEAD     = 2'b00;
    localparam logic [1:0] BODY     = 2'b01;
    localparam logic [1:0] TAIL     = 2'b10;
    localparam logic [1:0] HEADTAIL = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } inj_state_t;

endpackage

// File: rtl/inj_credit_cnt.sv
// Per-VC downstream credit counter; saturates at DEPTH and flags overflow.
module inj_credit_cnt #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          ovf
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == FULL) begin
                ovf = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec && !inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= FULL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pe_inj_sched.sv
// PE injection scheduler: shares the local link between two VCs with
// head-to-tail packet locking, round-robin arbitration and credit tracking.
module pe_inj_sched
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [NVC-1:0]  req,
    input  logic [1:0]      ftype0,
    input  logic [1:0]      ftype1,
    input  logic [NVC-1:0]  credit_in,
    output logic [NVC-1:0]  grt,
    output logic [NVC-1:0]  sel,
    output logic            valid,
    output logic            lock,
    output logic [2*CW-1:0] cred,
    output logic            err
);

    inj_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       rr_q, rr_d;
    logic [1:0] sel_q, sel_d;
    logic       err_q, err_d;

    logic [CW-1:0] cred0, cred1;
    logic          ovf0, ovf1;
    logic [1:0]    elig;
    logic [1:0]    g;
    logic          gv;
    logic [1:0]    ft;
    logic          perr;

    inj_credit_cnt #(.DEPTH(DEPTH), .CW(CW)) u_cred0 (
        .clk (clk),
        .rst_(rst_),
        .inc (credit_in[0]),
        .dec (grt[0]),
        .cnt (cred0),
        .ovf (ovf0)
    );

    inj_credit_cnt #(.DEPTH(DEPTH), .CW(CW)) u_cred1 (
        .clk (clk),
        .rst_(rst_),
        .inc (credit_in[1]),
        .dec (grt[1]),
        .cnt (cred1),
        .ovf (ovf1)
    );

    assign elig = req & {(cred1 != '0), (cred0 != '0)};

    always_comb begin
        g       = 2'b00;
        gv      = 1'b0;
        ft      = ftype0;
        perr    = 1'b0;
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (elig == 2'b11) begin
                    g = rr_q ? 2'b10 : 2'b01;
                end else begin
                    g = elig;
                end
                gv = g[1];
                ft = gv ? ftype1 : ftype0;
                if (|g) begin
                    case (ft)
                        HEAD: begin
                            state_d = LOCK;
                            owner_d = gv;
                        end
                        HEADTAIL: rr_d = ~gv;
                        default: begin
                            perr = 1'b1;
                            rr_d = ~gv;
                        end
                    endcase
                end
            end
            LOCK: begin
                // Only the owner may send; the other VC waits for the tail.
                g[owner_q] = elig[owner_q];
                ft = owner_q ? ftype1 : ftype0;
                if (|g) begin
                    case (ft)
                        BODY: ;
                        TAIL: begin
                            state_d = IDLE;
                            rr_d    = ~owner_q;
                        end
                        default: begin
                            perr    = 1'b1;
                            state_d = IDLE;
                            rr_d    = ~owner_q;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grt   = rst_ ? g : 2'b00;
    assign valid = |grt;
    assign sel_d = (|grt) ? grt : sel_q;
    assign err_d = err_q | perr | ovf0 | ovf1;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            sel_q   <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign sel  = sel_q;
    assign lock = (state_q == LOCK);
    assign err  = err_q;
    assign cred = {cred1, cred0};

endmodule

// File: tb/tb_pe_inj_sched.sv
// Directed bench for pe_inj_sched: arbitration, locking, credits, errors.
module tb_pe_inj_sched;

    logic       clk;
    logic       rst_;
    logic [1:0] req;
    logic [1:0] ftype0;
    logic [1:0] ftype1;
    logic [1:0] credit_in;
    logic [1:0] grt;
    logic [1:0] sel;
    logic       valid;
    logic       lock;
    logic [5:0] cred;
    logic       err;

    int n_chk;
    int n_fail;

    localparam logic [1:0] HD = 2'b00;
    localparam logic [1:0] BD = 2'b01;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [1:0] HT = 2'b11;

    localparam logic [5:0] C44 = {3'd4, 3'd4};

    pe_inj_sched #(.DEPTH(4), .CW(3)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .req      (req),
        .ftype0   (ftype0),
        .ftype1   (ftype1),
        .credit_in(credit_in),
        .grt      (grt),
        .sel      (sel),
        .valid    (valid),
        .lock     (lock),
        .cred     (cred),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; then drive, then settle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_      = 1'b0;
        req       = 2'b11;
        ftype0    = HT;
        ftype1    = HT;
        credit_in = 2'b00;
        #13;
        chk("rst_grt", 8'(grt), 8'h0);
        chk("rst_lock", 8'(lock), 8'h0);
        req = 2'b00;
        rst_ = 1'b1;
        tick();
        #1;
        chk("idle_grt", 8'(grt), 8'h0);
        chk("idle_sel", 8'(sel), 8'h0);
        chk("idle_cred", 8'(cred), 8'(C44));
        chk("idle_lock", 8'(lock), 8'h0);
        chk("idle_err", 8'(err), 8'h0);

        // Single-flit contention alternates between VCs
        req = 2'b11; ftype0 = HT; ftype1 = HT;
        #1; chk("rr_g0", 8'(grt), 8'h1);
        chk("rr_valid", 8'(valid), 8'h1);
        tick(); #1; chk("rr_g1", 8'(grt), 8'h2);
        tick(); #1; chk("rr_g2", 8'(grt), 8'h1);
        tick(); #1; chk("rr_g3", 8'(grt), 8'h2);
        tick(); req = 2'b00; #1;
        chk("rr_cred", 8'(cred), 8'({3'd2, 3'd2}));
        chk("rr_lock", 8'(lock), 8'h0);
        chk("rr_sel", 8'(sel), 8'h2);
        credit_in = 2'b11;
        tick(); tick(); credit_in = 2'b00; #1;
        chk("refill1", 8'(cred), 8'(C44));
        chk("refill1_err", 8'(err), 8'h0);

        // VC0 packet locks out VC1
        req = 2'b11; ftype0 = HD; ftype1 = HT;
        #1; chk("pk_g0", 8'(grt), 8'h1);
        chk("pk_l0", 8'(lock), 8'h0);
        chk("pk_s0", 8'(sel), 8'h2);
        tick(); ftype0 = BD; #1;
        chk("pk_g1", 8'(grt), 8'h1);
        chk("pk_l1", 8'(lock), 8'h1);
        chk("pk_s1", 8'(sel), 8'h1);
        tick(); ftype0 = TL; #1;
        chk("pk_g2", 8'(grt), 8'h1);
        chk("pk_l2", 8'(lock), 8'h1);
        tick(); req = 2'b10; #1;
        chk("pk_g3", 8'(grt), 8'h2);
        chk("pk_l3", 8'(lock), 8'h0);
        chk("pk_s3", 8'(sel), 8'h1);
        tick(); req = 2'b00; #1;
        chk("pk_s4", 8'(sel), 8'h2);
        chk("pk_cred", 8'(cred), 8'({3'd3, 3'd1}));
        credit_in = 2'b11;
        tick(); credit_in = 2'b01;
        tick(); tick(); credit_in = 2'b00; #1;
        chk("refill2", 8'(cred), 8'(C44));

        // Credit stall inside a VC0 packet
        req = 2'b11; ftype0 = HD; ftype1 = HT;
        #1; chk("st_g0", 8'(grt), 8'h1);
        tick(); ftype0 = BD; #1; chk("st_g1", 8'(grt), 8'h1);
        tick(); #1; chk("st_g2", 8'(grt), 8'h1);
        tick(); #1; chk("st_g3", 8'(grt), 8'h1);
        tick(); #1;
        chk("st_stall", 8'(grt), 8'h0);
        chk("st_lock", 8'(lock), 8'h1);
        chk("st_cred0", 8'(cred), 8'({3'd4, 3'd0}));
        tick(); credit_in = 2'b01; #1;
        chk("st_stall2", 8'(grt), 8'h0);
        tick(); credit_in = 2'b01; #1;
        chk("st_resume", 8'(grt), 8'h1);
        tick(); credit_in = 2'b00; ftype0 = TL; #1;
        chk("st_simul", 8'(cred), 8'({3'd4, 3'd1}));
        chk("st_tail", 8'(grt), 8'h1);
        tick(); req = 2'b00; #1;
        chk("st_unlock", 8'(lock), 8'h0);
        chk("st_err", 8'(err), 8'h0);
        credit_in = 2'b01;
        tick(); tick(); tick(); tick(); credit_in = 2'b00; #1;
        chk("refill3", 8'(cred), 8'(C44));

        // BODY flit in IDLE is a protocol error
        req = 2'b01; ftype0 = BD; #1;
        chk("pe_grt", 8'(grt), 8'h1);
        chk("pe_err0", 8'(err), 8'h0);
        tick(); req = 2'b00; credit_in = 2'b01; #1;
        chk("pe_err1", 8'(err), 8'h1);
        chk("pe_lock", 8'(lock), 8'h0);
        tick(); credit_in = 2'b00; #1;
        chk("pe_cred", 8'(cred), 8'(C44));

        // Credit overflow at full count
        rst_ = 1'b0; #1;
        chk("ov_clr", 8'(err), 8'h0);
        rst_ = 1'b1;
        tick(); credit_in = 2'b10;
        tick(); credit_in = 2'b00; #1;
        chk("ov_cred", 8'(cred), 8'(C44));
        chk("ov_err", 8'(err), 8'h1);

        // Asynchronous reset mid-packet
        rst_ = 1'b0; #1; rst_ = 1'b1;
        tick(); req = 2'b01; ftype0 = HD;
        tick(); ftype0 = BD; #1;
        chk("ar_lock1", 8'(lock), 8'h1);
        chk("ar_sel1", 8'(sel), 8'h1);
        chk("ar_cred1", 8'(cred), 8'({3'd4, 3'd3}));
        #1; rst_ = 1'b0; #1;
        chk("ar_lock0", 8'(lock), 8'h0);
        chk("ar_sel0", 8'(sel), 8'h0);
        chk("ar_grt0", 8'(grt), 8'h0);
        chk("ar_cred", 8'(cred), 8'(C44));
        chk("ar_err", 8'(err), 8'h0);
        req = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
